// File: rtl/muldiv_unit_pkg.sv
// Shared CPU definitions for the multiply/divide unit: R-type Funct codes
// (same values the ALU control decoder uses), op-type and FSM state enums.
package muldiv_unit_pkg;

  localparam logic [5:0] F_MFHI  = 6'd16;
  localparam logic [5:0] F_MTHI  = 6'd17;
  localparam logic [5:0] F_MFLO  = 6'd18;
  localparam logic [5:0] F_MTLO  = 6'd19;
  localparam logic [5:0] F_MULT  = 6'd24;
  localparam logic [5:0] F_MULTU = 6'd25;
  localparam logic [5:0] F_DIV   = 6'd26;
  localparam logic [5:0] F_DIVU  = 6'd27;

  typedef enum logic {
    MUL = 1'b0,
    DIV = 1'b1
  } md_op_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } md_state_e;

endpackage

// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO; one bit per clock, XLEN iterations.
// Optional MULDIV_SIGNED_EN adds signed mult/div via magnitude iteration + fix-up.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [5:0]      funct,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hilo_rdata,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo,
  output logic            dbg_state
);

  localparam int CW = $clog2(XLEN);

  // Handshake: start is a request sampled only while idle (busy=0); there is
  // no ready back-pressure beyond busy, and start while busy is dropped.
  md_state_e       r_state;
  md_state_e       w_state_nxt;
  md_op_e          r_op;
  logic [CW-1:0]   r_cnt;
  logic [XLEN-1:0] r_hi;
  logic [XLEN-1:0] r_lo;
  logic [XLEN-1:0] r_wh;
  logic [XLEN-1:0] r_wl;
  logic [XLEN-1:0] r_b;
  logic            r_done;

  logic            w_is_mul;
  logic            w_is_div;
  logic            w_signed_op;
  logic            w_accept;
  logic            w_last;
  logic [XLEN-1:0] w_a_mag;
  logic [XLEN-1:0] w_b_mag;
  logic [XLEN:0]   w_sum;
  logic [XLEN:0]   w_shift;
  logic [XLEN:0]   w_diff;
  logic [XLEN-1:0] w_wh_nxt;
  logic [XLEN-1:0] w_wl_nxt;
  logic [XLEN-1:0] w_hi_res;
  logic [XLEN-1:0] w_lo_res;

`ifdef MULDIV_SIGNED_EN
  logic            r_sgn;
  logic            r_neg_q;
  logic            r_neg_r;
  logic            r_div0;
  logic [XLEN-1:0] r_dividend;
`endif

  always_comb begin
    w_is_mul    = (funct == F_MULTU);
    w_is_div    = (funct == F_DIVU);
    w_signed_op = 1'b0;
`ifdef MULDIV_SIGNED_EN
    if (funct == F_MULT) begin
      w_is_mul    = 1'b1;
      w_signed_op = 1'b1;
    end
    if (funct == F_DIV) begin
      w_is_div    = 1'b1;
      w_signed_op = 1'b1;
    end
`endif
  end

  assign w_a_mag = (w_signed_op && op_a[XLEN-1]) ? -op_a : op_a;
  assign w_b_mag = (w_signed_op && op_b[XLEN-1]) ? -op_b : op_b;

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start && (w_is_mul || w_is_div)) begin
          w_accept    = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (r_cnt == CW'(XLEN - 1)) begin
          w_last      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Multiply keeps {partial product, multiplier} in {r_wh, r_wl} and shifts
  // right; divide keeps {remainder, dividend/quotient} and shifts left.
  // Both finish with HI in r_wh and LO in r_wl.
  always_comb begin
    w_sum   = {1'b0, r_wh} + (r_wl[0] ? {1'b0, r_b} : {(XLEN + 1){1'b0}});
    w_shift = {r_wh, r_wl[XLEN-1]};
    w_diff  = w_shift - {1'b0, r_b};
    if (r_op == MUL) begin
      w_wh_nxt = w_sum[XLEN:1];
      w_wl_nxt = {w_sum[0], r_wl[XLEN-1:1]};
    end else if (!w_diff[XLEN]) begin
      w_wh_nxt = w_diff[XLEN-1:0];
      w_wl_nxt = {r_wl[XLEN-2:0], 1'b1};
    end else begin
      w_wh_nxt = w_shift[XLEN-1:0];
      w_wl_nxt = {r_wl[XLEN-2:0], 1'b0};
    end
  end

  // Unsigned divide-by-zero needs no special case: every trial subtract
  // succeeds, giving an all-ones quotient and the dividend as remainder.
  always_comb begin
    w_hi_res = w_wh_nxt;
    w_lo_res = w_wl_nxt;
`ifdef MULDIV_SIGNED_EN
    if (r_sgn) begin
      if (r_op == MUL) begin
        if (r_neg_q) {w_hi_res, w_lo_res} = -{w_wh_nxt, w_wl_nxt};
      end else if (r_div0) begin
        w_lo_res = '1;
        w_hi_res = r_dividend;
      end else begin
        if (r_neg_q) w_lo_res = -w_wl_nxt;
        if (r_neg_r) w_hi_res = -w_wh_nxt;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op   <= MUL;
      r_cnt  <= '0;
      r_hi   <= '0;
      r_lo   <= '0;
      r_wh   <= '0;
      r_wl   <= '0;
      r_b    <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_last;
      if (w_accept) begin
        r_op  <= w_is_mul ? MUL : DIV;
        r_b   <= w_b_mag;
        r_wh  <= '0;
        r_wl  <= w_a_mag;
        r_cnt <= '0;
      end else if (r_state == S_RUN) begin
        r_wh  <= w_wh_nxt;
        r_wl  <= w_wl_nxt;
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_last) begin
        r_hi <= w_hi_res;
        r_lo <= w_lo_res;
      end else if (r_state == S_IDLE && start) begin
        if (funct == F_MTHI) r_hi <= op_a;
        if (funct == F_MTLO) r_lo <= op_a;
      end
    end
  end

`ifdef MULDIV_SIGNED_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sgn      <= 1'b0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_div0     <= 1'b0;
      r_dividend <= '0;
    end else if (w_accept) begin
      r_sgn      <= w_signed_op;
      r_neg_q    <= w_signed_op & (op_a[XLEN-1] ^ op_b[XLEN-1]);
      r_neg_r    <= w_signed_op & op_a[XLEN-1];
      r_div0     <= w_signed_op & (op_b == '0);
      r_dividend <= op_a;
    end
  end
`endif

  always_comb begin
    hilo_rdata = '0;
    if (funct == F_MFHI)      hilo_rdata = r_hi;
    else if (funct == F_MFLO) hilo_rdata = r_lo;
  end

  assign busy      = (r_state == S_RUN);
  assign done      = r_done;
  assign hi        = r_hi;
  assign lo        = r_lo;
  assign dbg_state = r_state;

endmodule
